// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_arb_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  localparam int DEF_BIN_W = 12;
  localparam int DEF_BCD_W = 16;
  localparam int CONV_LAT  = 26;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one un-resettable iterative binary-to-BCD converter.
//  state    | meaning
//  ST_FLUSH | wait out any conversion left running across reset/timeout
//  ST_IDLE  | arbitrate among pending requests
//  ST_ISSUE | pulse conv_en for the granted operand
//  ST_WAIT  | wait for conv_rdy, abandon after TIMEOUT cycles
//  ST_DONE  | ack pulse, result valid on bcd_out
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = DEF_BIN_W,
  parameter int BCD_W   = DEF_BCD_W,
  parameter int TIMEOUT = 40,
  parameter int FLUSH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] bin_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [BCD_W-1:0]       bcd_out,
  output logic                   err,
  output logic                   busy,
  output logic                   conv_en,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic [BCD_W-1:0]       conv_bcd,
  input  logic                   conv_rdy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int FL_W  = $clog2(FLUSH);

  arb_state_t       state, state_d;
  logic [FL_W-1:0]  flush_cnt, flush_d;
  logic [TO_W-1:0]  timer, timer_d;
  logic [IDX_W-1:0] idx, idx_d, rr_ptr, ptr_d;
  logic [N_REQ-1:0] gnt_d, ack_d;
  logic [BCD_W-1:0] bcd_d;
  logic [BIN_W-1:0] bin_d;
  logic             err_d, en_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_d = state;
    flush_d = flush_cnt;
    timer_d = timer;
    idx_d   = idx;
    ptr_d   = rr_ptr;
    gnt_d   = gnt;
    ack_d   = '0;
    err_d   = 1'b0;
    en_d    = 1'b0;
    bin_d   = conv_bin;
    bcd_d   = bcd_out;
    case (state)
      ST_FLUSH: begin
        gnt_d = '0;
        if (flush_cnt == FL_W'(FLUSH - 1)) begin
          flush_d = '0;
          state_d = ST_IDLE;
        end else begin
          flush_d = flush_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          bin_d   = bin_in[pick_idx*BIN_W +: BIN_W];
          gnt_d   = pick_onehot;
          en_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_rdy) begin
          bcd_d      = conv_bcd;
          ack_d[idx] = 1'b1;
          gnt_d      = '0;
          state_d    = ST_DONE;
        end else if (timer == TO_W'(TIMEOUT - 1)) begin
          // converter may still be running; flush before reusing it
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = idx;
          flush_d = '0;
          state_d = ST_FLUSH;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = idx;
        state_d = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FLUSH;
      flush_cnt <= '0;
      timer     <= '0;
      idx       <= '0;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      conv_en   <= 1'b0;
      conv_bin  <= '0;
      bcd_out   <= '0;
    end else begin
      state     <= state_d;
      flush_cnt <= flush_d;
      timer     <= timer_d;
      idx       <= idx_d;
      rr_ptr    <= ptr_d;
      gnt       <= gnt_d;
      ack       <= ack_d;
      err       <= err_d;
      conv_en   <= en_d;
      conv_bin  <= bin_d;
      bcd_out   <= bcd_d;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed sequences, vector table and randomized traffic.
module tb_bcd_conv_arbiter;
  import bcd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [47:0] bin_in = '0;
  logic [3:0]  gnt, ack;
  logic [15:0] bcd_out;
  logic        err, busy, conv_en;
  logic [11:0] conv_bin;
  logic [15:0] conv_bcd = '0;
  logic        conv_rdy = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int last_win = 3;
  logic suppress = 1'b0;

  bcd_conv_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt), .ack(ack),
    .bcd_out(bcd_out), .err(err), .busy(busy), .conv_en(conv_en),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd), .conv_rdy(conv_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input logic [11:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_model(input logic [3:0] r, input int last);
    for (int d = 1; d <= 4; d++)
      if (r[(last + d) % 4]) return (last + d) % 4;
    return 0;
  endfunction

  // converter model: no reset, result pulse CONV_LAT cycles after the start cycle
  logic        run_m = 1'b0;
  int          cnt_m = 0;
  logic [11:0] val_m = '0;
  always @(posedge clk) begin
    conv_rdy <= 1'b0;
    if (conv_en) begin
      run_m <= 1'b1;
      cnt_m <= CONV_LAT - 1;
      val_m <= conv_bin;
    end else if (run_m) begin
      if (cnt_m == 1) begin
        run_m <= 1'b0;
        if (!suppress) begin
          conv_rdy <= 1'b1;
          conv_bcd <= to_bcd(val_m);
        end
      end
      cnt_m <= cnt_m - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_win = 3;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_bcd"}, 32'(bcd_out), 0);
    chk({tag, "_en"}, 32'(conv_en), 0);
    chk({tag, "_bin"}, 32'(conv_bin), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  // one full transaction for requester idx; drop_at: -1 hold, 0 drop at ack, k drop k cycles after issue
  task automatic serve(input int idx, input logic [15:0] exp_bcd, input int drop_at,
                       input string tag, output int en_wait);
    int n, lat, bad;
    n = 0;
    while (conv_en !== 1'b1 && n < 400) begin tick(); n++; end
    en_wait = n;
    chk({tag, "_en_seen"}, 32'(conv_en), 1);
    if (conv_en !== 1'b1) return;
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b1 << idx));
    chk({tag, "_conv_bin"}, 32'(conv_bin), 32'(bin_in[idx*12 +: 12]));
    lat = 0;
    bad = 0;
    while (ack === 4'b0 && lat < 100) begin
      if (gnt !== (4'b1 << idx) || busy !== 1'b1) bad++;
      tick();
      lat++;
      if (drop_at > 0 && lat == drop_at) req[idx] = 1'b0;
    end
    chk({tag, "_gnt_held"}, 32'(bad), 0);
    chk({tag, "_ack_lat"}, 32'(lat), 27);
    chk({tag, "_ack"}, 32'(ack), 32'(4'b1 << idx));
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, "_gnt_done"}, 32'(gnt), 0);
    if (drop_at == 0) req[idx] = 1'b0;
    last_win = idx;
  endtask

  typedef struct {
    int          idx;
    logic [11:0] bin;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int w, k, acks, bad;
    vt[0] = '{0, 12'd0,    16'h0000};
    vt[1] = '{3, 12'd9,    16'h0009};
    vt[2] = '{1, 12'd10,   16'h0010};
    vt[3] = '{2, 12'd999,  16'h0999};
    vt[4] = '{0, 12'd1000, 16'h1000};
    vt[5] = '{3, 12'd4095, 16'h4095};

    // 1: flush after reset, then req0 served
    req[0] = 1'b1;
    bin_in[0 +: 12] = 12'd255;
    do_reset();
    check_reset("t1_rst");
    serve(0, 16'h0255, 0, "t1", w);
    chk("t1_en_wait", 32'(w), 33);

    // 2: req1 and req2 together with rr_ptr at 0
    bin_in[12 +: 12] = 12'd4095;
    bin_in[24 +: 12] = 12'd9;
    req[1] = 1'b1;
    req[2] = 1'b1;
    serve(1, 16'h4095, 0, "t2a", w);
    chk("t2_next_en_wait", 32'(w), 2);
    serve(2, 16'h0009, 0, "t2b", w);
    chk("t2b_en_wait", 32'(w), 2);

    // 3: all four held continuously from reset
    for (int i = 0; i < 4; i++) bin_in[i*12 +: 12] = 12'($urandom_range(4095, 0));
    req = 4'hF;
    do_reset();
    check_reset("t3_rst");
    for (int g = 0; g < 8; g++) begin
      serve(g % 4, to_bcd(bin_in[(g%4)*12 +: 12]), -1, $sformatf("t3_g%0d", g), w);
      if (g > 0) chk($sformatf("t3_g%0d_en_wait", g), 32'(w), 2);
    end
    req = '0;

    // vector table, single requester each
    for (int v = 0; v < 6; v++) begin
      bin_in[vt[v].idx*12 +: 12] = vt[v].bin;
      req[vt[v].idx] = 1'b1;
      serve(vt[v].idx, vt[v].exp, 0, $sformatf("vec%0d", v), w);
      tick();
      chk($sformatf("vec%0d_ack_pulse", v), 32'(ack), 0);
    end

    // 4: converter never answers -> timeout, flush, retry
    suppress = 1'b1;
    bin_in[24 +: 12] = 12'd123;
    req[2] = 1'b1;
    k = 0;
    while (conv_en !== 1'b1 && k < 100) begin tick(); k++; end
    chk("t4_en_seen", 32'(conv_en), 1);
    chk("t4_gnt", 32'(gnt), 32'h4);
    k = 0;
    acks = 0;
    while (err !== 1'b1 && k < 100) begin
      tick();
      k++;
      if (ack !== 4'b0) acks++;
    end
    chk("t4_err_at", 32'(k), 41);
    chk("t4_no_ack", 32'(acks), 0);
    chk("t4_gnt_cleared", 32'(gnt), 0);
    suppress = 1'b0;
    tick();
    chk("t4_err_pulse", 32'(err), 0);
    serve(2, 16'h0123, 0, "t4_retry", w);
    chk("t4_retry_en_wait", 32'(w), 32);

    // 5: reset mid-conversion, stray rdy lands during flush
    bin_in[12 +: 12] = 12'd777;
    req[1] = 1'b1;
    k = 0;
    while (conv_en !== 1'b1 && k < 100) begin tick(); k++; end
    chk("t5_en_seen", 32'(conv_en), 1);
    repeat (10) tick();
    req = '0;
    do_reset();
    check_reset("t5_rst");
    bad = 0;
    repeat (40) begin
      tick();
      if (ack !== 4'b0 || bcd_out !== 16'h0 || conv_en !== 1'b0 || err !== 1'b0) bad++;
    end
    chk("t5_flush_quiet", 32'(bad), 0);
    bin_in[12 +: 12] = 12'd888;
    req[1] = 1'b1;
    serve(1, 16'h0888, 0, "t5_next", w);

    // 6: requester drops 5 cycles after grant
    bin_in[36 +: 12] = 12'd1234;
    req[3] = 1'b1;
    serve(3, 16'h1234, 5, "t6", w);

    // randomized traffic against round-robin reference
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++)
        if (req[i] == 1'b0 && $urandom_range(1, 0) == 1) begin
          bin_in[i*12 +: 12] = 12'($urandom_range(4095, 0));
          req[i] = 1'b1;
        end
      if (req == 4'b0) begin
        k = $urandom_range(3, 0);
        bin_in[k*12 +: 12] = 12'($urandom_range(4095, 0));
        req[k] = 1'b1;
      end
      w = rr_model(req, last_win);
      serve(w, to_bcd(bin_in[w*12 +: 12]), 0, $sformatf("rnd%0d", t), k);
    end
    req = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
